mont_convert: RTL and testbench

Bit-serial radix-2 Montgomery domain converter for the RSA decryption datapath. It consumes the constant R² mod n produced by the constant generator. On request it maps a plain operand x into the Montgomery domain (x·R mod n) or maps a Montgomery-domain value back out (x·R⁻¹ mod n), where R = 2^WIDTH. It sits between the constant generator and the modular exponentiation core.

---
 rtl/mont_convert_pkg.sv | 16 +
 rtl/mont_convert_if.sv | 24 ++
 rtl/mont_convert_step.sv | 23 ++
 rtl/mont_convert.sv | 123 ++++++++++++
 tb/tb_mont_convert.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mont_convert_pkg.sv
// Shared types and constants for the Montgomery domain converter.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional err output is enabled by MONT_CONV_ERR_EN.
package mont_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam int   MONT_WIDTH    = 4096;
    localparam logic DIR_TO_MONT   = 1'b0;
    localparam logic DIR_FROM_MONT = 1'b1;

endpackage

// File: rtl/mont_convert_if.sv
// Request/result bundle between the requester and mont_convert.
// Latency: n/a (wiring only).
// Backpressure: start is honoured only while busy is low; err exists only with MONT_CONV_ERR_EN.
interface mont_convert_if #(
    parameter int WIDTH = mont_pkg::MONT_WIDTH
);
    logic             start;
    logic             dir;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] r2;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
`ifdef MONT_CONV_ERR_EN
    logic             err;

    modport master (output start, dir, n, r2, x, input  y, busy, done, err);
    modport slave  (input  start, dir, n, r2, x, output y, busy, done, err);
`else
    modport master (output start, dir, n, r2, x, input  y, busy, done);
    modport slave  (input  start, dir, n, r2, x, output y, busy, done);
`endif
endinterface

// File: rtl/mont_convert_step.sv
// One radix-2 Montgomery iteration: S' = (S + a_bit*b [+ n]) / 2.
// Latency: combinational.
// Backpressure: none.
module mont_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+1:0] i_s,
    input  logic             i_a_bit,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH+1:0] o_s
);
    // S < 2n and b < n keep every intermediate below 4n, so WIDTH+2 bits never overflow.
    logic [WIDTH+1:0] w_t1;
    logic [WIDTH+1:0] w_t2;

    // Add b when the current multiplier bit is set, then add n to make the sum even.
    always_comb begin
        w_t1 = i_s + (i_a_bit ? {2'b00, i_b} : '0);
        w_t2 = w_t1 + (w_t1[0] ? {2'b00, i_n} : '0);
        o_s  = w_t2 >> 1;
    end
endmodule

// File: rtl/mont_convert.sv
// Bit-serial Montgomery domain converter: y = x*b*R^-1 mod n with b = r2 (into) or 1 (out of).
// Latency: done pulses WIDTH+1 cycles after the start edge (1 cycle on a rejected request).
// Backpressure: start ignored while busy; optional MONT_CONV_ERR_EN adds operand checks and err.
module mont_convert
    import mont_pkg::*;
#(
    parameter int WIDTH = MONT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    mont_convert_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH+1:0] r_s;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_y;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_b_sel;
    logic [WIDTH+1:0] w_s_next;
    logic [WIDTH+1:0] w_n_ext;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    assign w_b_sel = (bus.dir == DIR_TO_MONT) ? bus.r2 : WIDTH'(1);
    assign w_n_ext = {2'b00, r_n};
    assign w_ge    = (r_s >= w_n_ext);
    // When S >= n the true difference is below n, so the low WIDTH bits are exact.
    assign w_diff  = r_s[WIDTH-1:0] - r_n;

`ifdef MONT_CONV_ERR_EN
    logic r_err;
    logic r_bad;
    logic w_bad;

    assign w_bad   = ~bus.n[0] | (bus.x >= bus.n);
    assign bus.err = r_err;
`endif

    mont_step #(.WIDTH(WIDTH)) u_step (
        .i_s     (r_s),
        .i_a_bit (r_a[0]),
        .i_b     (r_b),
        .i_n     (r_n),
        .o_s     (w_s_next)
    );

    // Conversion FSM: latch operands, iterate WIDTH times, then reduce once and report.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_n     <= '0;
            r_b     <= '0;
            r_a     <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_y     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef MONT_CONV_ERR_EN
            r_err   <= 1'b0;
            r_bad   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_n     <= bus.n;
                        r_b     <= w_b_sel;
                        r_a     <= bus.x;
                        r_s     <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ITER;
`ifdef MONT_CONV_ERR_EN
                        r_err   <= 1'b0;
                        r_bad   <= w_bad;
                        // Bad operands bypass the iterations and are reported on the next edge.
                        if (w_bad) begin
                            r_state <= FINAL;
                        end
`endif
                    end
                end
                ITER: begin
                    r_s   <= w_s_next;
                    r_a   <= r_a >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= FINAL;
                    end
                end
                FINAL: begin
                    r_y     <= w_ge ? w_diff : r_s[WIDTH-1:0];
`ifdef MONT_CONV_ERR_EN
                    if (r_bad) begin
                        r_y   <= '0;
                        r_err <= 1'b1;
                    end
`endif
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.y    = r_y;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_mont_convert.sv
// Self-checking bench for mont_convert at WIDTH=8 and WIDTH=4096 against an arithmetic model.
// Latency: checks done timing of WIDTH+1 cycles (1 cycle for rejected requests with MONT_CONV_ERR_EN).
// Backpressure: checks that start while busy is ignored and back-to-back starts are accepted.
module tb_mont_convert;
    import mont_pkg::*;

    logic clk = 1'b0;
    logic rst8_n;
    logic rst4k_n;

    always #5 clk = ~clk;

    mont_convert_if #(.WIDTH(8))          if8  ();
    mont_convert_if #(.WIDTH(MONT_WIDTH)) if4k ();

    mont_convert #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst8_n),
        .bus   (if8.slave)
    );

    mont_convert #(.WIDTH(MONT_WIDTH)) dut4k (
        .clk   (clk),
        .rst_n (rst4k_n),
        .bus   (if4k.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: x*R mod n with R = 256.
    function automatic int ref_to(input int xx, input int nn);
        return (xx * 256) % nn;
    endfunction

    // Reference: the unique y < n with y*R mod n == x.
    function automatic int ref_from(input int xx, input int nn);
        for (int yv = 0; yv < nn; yv++) begin
            if (((yv * 256) % nn) == (xx % nn)) return yv;
        end
        return -1;
    endfunction

    // Big reference: v * 2^k mod n by repeated modular doubling.
    function automatic logic [MONT_WIDTH-1:0] big_shift_mod(input logic [MONT_WIDTH-1:0] v0,
                                                            input logic [MONT_WIDTH-1:0] nn,
                                                            input int k);
        logic [MONT_WIDTH:0] v;
        v = {1'b0, v0};
        for (int i = 0; i < k; i++) begin
            v = {v[MONT_WIDTH-1:0], 1'b0};
            if (v >= {1'b0, nn}) v = v - {1'b0, nn};
        end
        return v[MONT_WIDTH-1:0];
    endfunction

    // Issue one 8-bit request starting at a negedge; scrambles inputs after the start edge.
    task automatic drive8(input logic d, input int nn, input int rr, input int xx,
                          output logic [7:0] yy, output int lat);
        if8.start = 1'b1;
        if8.dir   = d;
        if8.n     = 8'(nn);
        if8.r2    = 8'(rr);
        if8.x     = 8'(xx);
        @(negedge clk);
        if8.start = 1'b0;
        if8.x     = 8'($urandom);
        if8.r2    = 8'($urandom);
        if8.n     = 8'($urandom);
        if8.dir   = 1'($urandom);
        lat = 0;
        while (!if8.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!if8.done) lat = -1;
        yy = if8.y;
    endtask

    task automatic drive4k(input logic d, input logic [MONT_WIDTH-1:0] nn,
                           input logic [MONT_WIDTH-1:0] rr, input logic [MONT_WIDTH-1:0] xx,
                           output logic [MONT_WIDTH-1:0] yy, output int lat);
        if4k.start = 1'b1;
        if4k.dir   = d;
        if4k.n     = nn;
        if4k.r2    = rr;
        if4k.x     = xx;
        @(negedge clk);
        if4k.start = 1'b0;
        if4k.x     = '0;
        lat = 0;
        while (!if4k.done && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        if (!if4k.done) lat = -1;
        yy = if4k.y;
    endtask

    task automatic test_reset();
        rst8_n = 1'b0; rst4k_n = 1'b0;
        if8.start = 1'b0;  if8.dir = 1'b0;  if8.n = '0;  if8.r2 = '0;  if8.x = '0;
        if4k.start = 1'b0; if4k.dir = 1'b0; if4k.n = '0; if4k.r2 = '0; if4k.x = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (if8.y !== 8'd0) begin n_bad++; $display("FAIL reset y: got %0d expected 0", if8.y); end
        n_cmp++; if (if8.busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b expected 0", if8.busy); end
        n_cmp++; if (if8.done !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b expected 0", if8.done); end
        n_cmp++; if (if4k.busy !== 1'b0) begin n_bad++; $display("FAIL reset busy4k: got %b expected 0", if4k.busy); end
`ifdef MONT_CONV_ERR_EN
        n_cmp++; if (if8.err !== 1'b0) begin n_bad++; $display("FAIL reset err: got %b expected 0", if8.err); end
`endif
        rst8_n = 1'b1; rst4k_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_to_mont();
        logic [7:0] yy;
        int lat, nn, xx;
        drive8(DIR_TO_MONT, 13, 3, 5, yy, lat);
        n_cmp++; if (yy !== 8'd6) begin n_bad++; $display("FAIL to_mont x5: got %0d expected 6", yy); end
        n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL to_mont latency: got %0d expected 9", lat); end
        n_cmp++; if (if8.busy !== 1'b0) begin n_bad++; $display("FAIL busy at done: got %b expected 0", if8.busy); end
        drive8(DIR_TO_MONT, 13, 3, 1, yy, lat);
        n_cmp++; if (yy !== 8'd9) begin n_bad++; $display("FAIL to_mont x1: got %0d expected 9", yy); end
        for (int k = 0; k < 8; k++) begin
            nn = 2 * $urandom_range(1, 127) + 1;
            xx = $urandom_range(0, nn - 1);
            drive8(DIR_TO_MONT, nn, 65536 % nn, xx, yy, lat);
            n_cmp++;
            if (int'(yy) != ref_to(xx, nn) || lat != 9) begin
                n_bad++;
                $display("FAIL to_mont rand n=%0d x=%0d: got %0d lat %0d expected %0d lat 9",
                         nn, xx, yy, lat, ref_to(xx, nn));
            end
        end
    endtask

    task automatic test_from_mont();
        logic [7:0] ym, yb;
        int lat, lat2;
        drive8(DIR_FROM_MONT, 13, 0, 6, yb, lat);
        n_cmp++; if (yb !== 8'd5) begin n_bad++; $display("FAIL from_mont x6: got %0d expected 5", yb); end
        drive8(DIR_FROM_MONT, 13, 0, 0, yb, lat);
        n_cmp++; if (yb !== 8'd0) begin n_bad++; $display("FAIL from_mont x0: got %0d expected 0", yb); end
        for (int v = 0; v < 13; v++) begin
            drive8(DIR_TO_MONT, 13, 3, v, ym, lat);
            drive8(DIR_FROM_MONT, 13, 0, int'(ym), yb, lat2);
            n_cmp++;
            if (int'(ym) != ref_to(v, 13) || int'(yb) != v || ref_from(int'(ym), 13) != v) begin
                n_bad++;
                $display("FAIL round_trip v=%0d: got mont %0d back %0d expected mont %0d back %0d",
                         v, ym, yb, ref_to(v, 13), v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] yy;
        int lat;
        drive8(DIR_TO_MONT, 255, 1, 254, yy, lat);
        n_cmp++; if (yy !== 8'd254) begin n_bad++; $display("FAIL final_sub x254: got %0d expected 254", yy); end
        // The driver raises start at the same negedge done was seen, i.e. the cycle after done.
        drive8(DIR_TO_MONT, 255, 1, 200, yy, lat);
        n_cmp++;
        if (yy !== 8'(ref_to(200, 255)) || lat != 9) begin
            n_bad++;
            $display("FAIL back_to_back: got %0d lat %0d expected %0d lat 9", yy, lat, ref_to(200, 255));
        end
    endtask

    task automatic test_ignore_and_abort();
        int dones;
        // Second start at cycle 3 of a running conversion must be dropped.
        if8.start = 1'b1; if8.dir = DIR_TO_MONT; if8.n = 8'd13; if8.r2 = 8'd3; if8.x = 8'd5;
        @(negedge clk); if8.start = 1'b0;
        @(negedge clk); @(negedge clk);
        if8.start = 1'b1; if8.x = 8'd7;
        @(negedge clk); if8.start = 1'b0;
        dones = 0;
        for (int c = 0; c < 25; c++) begin
            if (if8.done) dones++;
            @(negedge clk);
        end
        n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL ignore_start dones: got %0d expected 1", dones); end
        n_cmp++; if (if8.y !== 8'd6) begin n_bad++; $display("FAIL ignore_start y: got %0d expected 6", if8.y); end
        n_cmp++; if (if8.busy !== 1'b0) begin n_bad++; $display("FAIL ignore_start busy: got %b expected 0", if8.busy); end
        // Abort with reset at cycle 4; a start presented during reset must lose.
        if8.start = 1'b1; if8.x = 8'd1;
        @(negedge clk); if8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst8_n = 1'b0; if8.start = 1'b1;
        @(negedge clk);
        rst8_n = 1'b1; if8.start = 1'b0;
        n_cmp++; if (if8.busy !== 1'b0) begin n_bad++; $display("FAIL abort busy: got %b expected 0", if8.busy); end
        n_cmp++; if (if8.y !== 8'd0) begin n_bad++; $display("FAIL abort y: got %0d expected 0", if8.y); end
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            if (if8.done || if8.busy) dones++;
            @(negedge clk);
        end
        n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL abort activity: got %0d cycles expected 0", dones); end
    endtask

`ifdef MONT_CONV_ERR_EN
    task automatic test_err();
        logic [7:0] yy;
        int lat;
        drive8(DIR_TO_MONT, 12, 3, 5, yy, lat);
        n_cmp++;
        if (lat != 1 || if8.err !== 1'b1 || yy !== 8'd0) begin
            n_bad++;
            $display("FAIL err even_n: got lat %0d err %b y %0d expected lat 1 err 1 y 0", lat, if8.err, yy);
        end
        drive8(DIR_TO_MONT, 13, 3, 5, yy, lat);
        n_cmp++;
        if (lat != 9 || if8.err !== 1'b0 || yy !== 8'd6) begin
            n_bad++;
            $display("FAIL err cleared: got lat %0d err %b y %0d expected lat 9 err 0 y 6", lat, if8.err, yy);
        end
        drive8(DIR_TO_MONT, 13, 3, 13, yy, lat);
        n_cmp++;
        if (lat != 1 || if8.err !== 1'b1 || yy !== 8'd0) begin
            n_bad++;
            $display("FAIL err x_ge_n: got lat %0d err %b y %0d expected lat 1 err 1 y 0", lat, if8.err, yy);
        end
    endtask
`endif

    task automatic test_wide();
        logic [MONT_WIDTH-1:0] nn, xx, rr, ym, yb, exp_m;
        int lat;
        for (int i = 0; i < MONT_WIDTH / 32; i++) begin
            nn[i*32 +: 32] = $urandom;
            xx[i*32 +: 32] = $urandom;
        end
        nn[MONT_WIDTH-1] = 1'b1;
        nn[0]            = 1'b1;
        xx[MONT_WIDTH-1] = 1'b0;
        rr    = big_shift_mod(1, nn, 2 * MONT_WIDTH);
        exp_m = big_shift_mod(xx, nn, MONT_WIDTH);
        drive4k(DIR_TO_MONT, nn, rr, xx, ym, lat);
        n_cmp++; if (lat != MONT_WIDTH + 1) begin n_bad++; $display("FAIL wide latency: got %0d expected %0d", lat, MONT_WIDTH + 1); end
        n_cmp++;
        if (ym !== exp_m) begin
            n_bad++;
            $display("FAIL wide to_mont low32: got %h expected %h", ym[31:0], exp_m[31:0]);
        end
        drive4k(DIR_FROM_MONT, nn, rr, ym, yb, lat);
        n_cmp++;
        if (yb !== xx || lat != MONT_WIDTH + 1) begin
            n_bad++;
            $display("FAIL wide round_trip low32: got %h lat %0d expected %h lat %0d",
                     yb[31:0], lat, xx[31:0], MONT_WIDTH + 1);
        end
    endtask

    initial begin
        test_reset();
        test_to_mont();
        test_from_mont();
        test_back_to_back();
        test_ignore_and_abort();
`ifdef MONT_CONV_ERR_EN
        test_err();
`endif
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
